// File: rtl/fifo_wr_ctrl.sv
// Write-side async FIFO controller: binary/Gray write pointer,
// look-ahead full, almost-full, fill level and sticky overflow.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  input  logic                  wclr_ovf,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  wovf
);

  localparam int AW = ADDR_WIDTH;
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic [PW-1:0] rbin;
  logic          wfull_q, wfull_d;
  logic          waf_q, waf_d;
  logic          wovf_q, wovf_d;

  assign wen = winc & ~wfull_q;

  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  // Flags are computed from the post-write pointer so full is look-ahead.
  always_comb begin
    wbin_d   = wbin_q + PW'(wen);
    wptr_d   = wbin_d ^ (wbin_d >> 1);
    wlevel_d = wbin_d - rbin;
    wfull_d  = (wptr_d == {~wq2_rptr[AW:AW-1],
                           wq2_rptr[AW-2:0]});
    waf_d    = (wlevel_d >= PW'(AF_THRESH));
    wovf_d   = (winc & wfull_q) | (wovf_q & ~wclr_ovf);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      waf_q    <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      waf_q    <= waf_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr        = wbin_q[AW-1:0];
  assign wptr         = wptr_q;
  assign wlevel       = wlevel_q;
  assign wfull        = wfull_q;
  assign walmost_full = waf_q;
  assign wovf         = wovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: default (AW=3) and
// AW=4/AF=12 instances driven by directed vectors.
module tb_fifo_wr_ctrl;

  logic wclk = 1'b0;
  always #5 wclk = ~wclk;

  logic       wrst = 1'b1;
  logic       winc = 1'b0;
  logic [3:0] rptr = '0;
  logic       clr  = 1'b0;
  logic       wen;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       wfull, waf, wovf;
  logic [3:0] wlevel;

  logic       rst1  = 1'b1;
  logic       winc1 = 1'b0;
  logic [4:0] rptr1 = '0;
  logic       clr1  = 1'b0;
  logic       wen1;
  logic [3:0] waddr1;
  logic [4:0] wptr1;
  logic       wfull1, waf1, wovf1;
  logic [4:0] wlevel1;

  fifo_wr_ctrl u_dut0 (
    .wclk(wclk), .wrst(wrst), .winc(winc),
    .wq2_rptr(rptr), .wclr_ovf(clr), .wen(wen),
    .waddr(waddr), .wptr(wptr), .wfull(wfull),
    .walmost_full(waf), .wlevel(wlevel), .wovf(wovf)
  );

  fifo_wr_ctrl #(.ADDR_WIDTH(4), .AF_THRESH(12)) u_dut1 (
    .wclk(wclk), .wrst(rst1), .winc(winc1),
    .wq2_rptr(rptr1), .wclr_ovf(clr1), .wen(wen1),
    .waddr(waddr1), .wptr(wptr1), .wfull(wfull1),
    .walmost_full(waf1), .wlevel(wlevel1), .wovf(wovf1)
  );

  typedef struct {
    int   cyc;
    bit   d;
    logic ew;
    int   ea;
    int   ep;
    logic ef;
    logic eaf;
    int   el;
    logic eo;
    bit   c1;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   scyc  = 0;
  int   mcyc  = 0;

  function automatic int gray(input int n);
    return n ^ (n >> 1);
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, mcyc, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge wclk);
    scyc++;
  endtask

  task automatic step(
    input bit d, input logic inc, input int rp,
    input logic cl, input logic rs,
    input logic ew, input int ea, input int ep,
    input logic ef, input logic eaf, input int el,
    input logic eo, input bit c1
  );
    exp_t e;
    tick();
    if (d) begin
      winc1 = inc; rptr1 = 5'(rp); clr1 = cl; rst1 = rs;
    end else begin
      winc = inc; rptr = 4'(rp); clr = cl; wrst = rs;
    end
    e.cyc = scyc; e.d = d; e.ew = ew; e.ea = ea;
    e.ep = ep; e.ef = ef; e.eaf = eaf; e.el = el;
    e.eo = eo; e.c1 = c1;
    q.push_back(e);
  endtask

  // Monitor: samples 2ns after each falling edge, after stimulus settles.
  initial begin : monitor
    int prevp [2];
    exp_t e;
    int a_w, a_a, a_p, a_f, a_af, a_l, a_o;
    prevp[0] = 0;
    prevp[1] = 0;
    forever begin
      @(negedge wclk);
      #2;
      mcyc++;
      while (q.size() != 0 && q[0].cyc <= mcyc) begin
        e = q.pop_front();
        if (e.cyc != mcyc) begin
          cmp("stale_record", e.cyc, mcyc);
          continue;
        end
        if (e.d) begin
          a_w = int'(wen1); a_a = int'(waddr1);
          a_p = int'(wptr1); a_f = int'(wfull1);
          a_af = int'(waf1); a_l = int'(wlevel1);
          a_o = int'(wovf1);
        end else begin
          a_w = int'(wen); a_a = int'(waddr);
          a_p = int'(wptr); a_f = int'(wfull);
          a_af = int'(waf); a_l = int'(wlevel);
          a_o = int'(wovf);
        end
        cmp($sformatf("d%0d_wen", e.d), a_w, int'(e.ew));
        cmp($sformatf("d%0d_waddr", e.d), a_a, e.ea);
        cmp($sformatf("d%0d_wptr", e.d), a_p, e.ep);
        cmp($sformatf("d%0d_wfull", e.d), a_f, int'(e.ef));
        cmp($sformatf("d%0d_walmost_full", e.d),
            a_af, int'(e.eaf));
        cmp($sformatf("d%0d_wlevel", e.d), a_l, e.el);
        cmp($sformatf("d%0d_wovf", e.d), a_o, int'(e.eo));
        if (e.c1) begin
          cmp($sformatf("d%0d_gray_1bit", e.d),
              $countones(a_p ^ prevp[e.d]), 1);
        end
        prevp[e.d] = a_p;
      end
    end
  end

  initial begin : stim
    int b;
    // Reset and release.
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Fill 8 entries.
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0, 0, 1, i, gray(i), 0, i >= 6, i, 0, 0);
    end
    // Full: rejected writes, overflow set/clear/set-wins.
    step(0, 1, 0, 0, 0, 0, 0, 'b1100, 1, 1, 8, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 'b1100, 1, 1, 8, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 'b1100, 1, 1, 8, 1, 0);
    step(0, 1, 0, 1, 0, 0, 0, 'b1100, 1, 1, 8, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 'b1100, 1, 1, 8, 1, 0);
    // Read pointer advances to binary 3.
    step(0, 0, 'b0010, 0, 0, 0, 0, 'b1100, 1, 1, 8, 1, 0);
    step(0, 1, 'b0010, 0, 0, 1, 0, 'b1100, 0, 0, 5, 1, 0);
    step(0, 1, 'b0010, 0, 0, 1, 1, 'b1101, 0, 1, 6, 1, 0);
    step(0, 1, 'b0010, 0, 0, 1, 2, 'b1111, 0, 1, 7, 1, 0);
    step(0, 0, 'b0010, 1, 0, 0, 3, 'b1110, 1, 1, 8, 1, 0);
    step(0, 0, gray(9), 0, 0, 0, 3, 'b1110, 1, 1, 8, 0, 0);
    // Streaming with the read pointer two behind.
    for (int j = 0; j < 40; j++) begin
      b = (11 + j) % 16;
      step(0, 1, gray((b + 15) % 16), 0, 0,
           1, b % 8, gray(b), 0, 0, 2, 0, j > 0);
    end
    // Refill to full, overflow, then free to 5 entries.
    for (int k = 0; k < 6; k++) begin
      b = 3 + k;
      step(0, 1, gray(1), 0, 0,
           1, b % 8, gray(b), 0, (2 + k) >= 6, 2 + k, 0, 0);
    end
    step(0, 1, gray(1), 0, 0, 0, 1, gray(9), 1, 1, 8, 0, 0);
    step(0, 0, gray(4), 0, 0, 0, 1, gray(9), 1, 1, 8, 1, 0);
    step(0, 1, gray(4), 0, 0, 1, 1, gray(9), 0, 0, 5, 1, 0);
    // Asynchronous reset mid-burst, then first write.
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0);
    // Wider instance.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 0, 0, 0, 1, i, gray(i), 0, i >= 12, i, 0, 0);
    end
    step(1, 1, 0, 0, 0, 0, 0, gray(16), 1, 1, 16, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, gray(16), 1, 1, 16, 1, 0);
    repeat (3) tick();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Parametrised write-side controller for the async FIFO, and the successor to the fixed 8-deep write-pointer logic.
- Generates the binary write address, the Gray write pointer for CDC to the read domain, and a memory write enable.
- Adds registered full, programmable almost-full, fill level and a sticky overflow flag.
- Sits in the write clock domain, between the producer, the dual-port FIFO memory and the read-pointer 2-FF synchroniser.

Parameters:
ADDR_WIDTH  3  address width; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
AF_THRESH  6  walmost_full asserts when fill level >= AF_THRESH; legal range 1..DEPTH

Ports:
wclk  in  1  write-domain clock, all state on rising edge
wrst  in  1  asynchronous active-high reset
winc  in  1  write request from producer
wq2_rptr  in  ADDR_WIDTH+1  read pointer, Gray coded, already synchronised into wclk
wclr_ovf  in  1  clears wovf
wen  out  1  memory write enable, combinational: winc & ~wfull
waddr  out  ADDR_WIDTH  memory write address for the current cycle
wptr  out  ADDR_WIDTH+1  registered Gray write pointer, to read-domain synchroniser
wfull  out  1  registered full flag
walmost_full  out  1  registered almost-full flag
wlevel  out  ADDR_WIDTH+1  registered fill level, 0..DEPTH
wovf  out  1  sticky overflow flag

Behaviour:
- Reset (wrst=1, asynchronous): wbin, wptr, waddr, wlevel = 0; wfull, walmost_full, wovf = 0. Deassertion is taken synchronously by the instantiating reset synchroniser.
- Internal binary pointer:
  - wbin is ADDR_WIDTH+1 bits.
  - wbin_next = wbin + wen, modulo 2**(ADDR_WIDTH+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
- Per clock: wbin <= wbin_next; wptr <= wgray_next.
- waddr = wbin[ADDR_WIDTH-1:0], zero latency. The memory writes at waddr on the same edge on which wen=1.
- Read pointer conversion: rbin = Gray-to-binary(wq2_rptr), combinational, MSB-first XOR chain.
- wfull <= (wgray_next == {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]}), where AW = ADDR_WIDTH. This is look-ahead: wfull rises on the same edge as the write that fills the last entry.
- wlevel <= wbin_next - rbin, modulo 2**(ADDR_WIDTH+1). Always 0..DEPTH.
- walmost_full <= ((wbin_next - rbin) >= AF_THRESH).
- Full:
  - winc while wfull=1 is rejected: wen=0, no pointer or address change, no memory write.
  - wfull stays high until a wq2_rptr change frees space; it deasserts on the first edge after that change (pessimistic, never optimistic).
- Overflow:
  - winc & wfull sets wovf on the next edge.
  - wclr_ovf clears it.
  - Set wins if both occur in the same cycle.
  - wovf is sticky across any number of cycles.
- Wrap-around:
  - wbin wraps from 2**(ADDR_WIDTH+1)-1 to 0 and waddr from DEPTH-1 to 0 with no bubble.
  - Successive wptr values differ in exactly one bit.
- Simultaneous write and read-pointer advance in one cycle:
  - wlevel is unchanged net.
  - wfull is evaluated on the new pointers, so a write into the slot freed this cycle is legal only once wfull has dropped.
- Reset mid-operation: all state returns to reset values immediately, without waiting for wclk. A write in flight is discarded.
- The output flags and pointers are glitch-free registers. wen is the only combinational output.

Test Plan:
- Reset, then 8 writes with wq2_rptr=0 (defaults) -> waddr 0..7; wptr sequence 0001,0011,0010,0110,0111,0101,0100,1100; walmost_full=1 after the 6th write edge; wfull=1 and wlevel=8 after the 8th.
- FIFO full, winc=1 for 2 cycles -> wen=0, wptr stays 1100, wovf=1 from the first rejected edge. Then wclr_ovf=1 -> wovf=0. Then wclr_ovf and a rejected winc in the same cycle -> wovf stays 1.
- FIFO full, drive wq2_rptr=0010 (binary 3) -> wfull=0, wlevel=5, walmost_full=0 on the next edge. Then 3 writes -> wfull=1 again after the 3rd, waddr 0,1,2.
- 40 cycles of continuous write with a read pointer trailing by 2 -> waddr wraps 7->0, wbin wraps 15->0, every wptr step changes exactly one bit, wlevel stays 2, wfull never set.
- Assert wrst mid-burst with 5 entries and wovf=1 -> all outputs are 0 immediately, without a clock edge. A write on the first edge after release goes to waddr=0.
- ADDR_WIDTH=4, AF_THRESH=12: 16 writes -> walmost_full after the 12th, wfull after the 16th, wlevel=16, and a 17th winc sets wovf.
